wb_pipe_slave_ram: RTL and testbench

Wishbone B4 pipelined-mode slave (responder) with internal word-addressed RAM. It is the target side of the CPU's data bus: it accepts CYC/STB requests, answers each one with exactly one ACK_O or ERR_O, and asserts STALL_O when its request queue is full. It provides the memory/peripheral endpoint for CPU bring-up and bus verification.

---
 rtl/wb_pipe_slave_ram_if.sv | 27 ++
 rtl/wb_pipe_slave_ram.sv | 141 ++++++++++++++
 tb/tb_wb_pipe_slave_ram.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_pipe_slave_ram_if.sv
// Wishbone B4 pipelined bus bundle between a single master and the RAM responder.
// Signal names keep the Wishbone _I/_O suffixes as seen from the slave side.
interface wb_pipe_slave_ram_if #(
   parameter int AW = 16,
   parameter int DW = 32
);
   logic          CYC_I;
   logic          STB_I;
   logic          LOCK_I;
   logic          WE_I;
   logic [AW-1:0] ADR_I;
   logic [DW-1:0] DAT_I;
   logic [DW-1:0] DAT_O;
   logic          ACK_O;
   logic          ERR_O;
   logic          STALL_O;

   modport slave (
      input  CYC_I, STB_I, LOCK_I, WE_I, ADR_I, DAT_I,
      output DAT_O, ACK_O, ERR_O, STALL_O
   );

   modport master (
      output CYC_I, STB_I, LOCK_I, WE_I, ADR_I, DAT_I,
      input  DAT_O, ACK_O, ERR_O, STALL_O
   );
endinterface

// File: rtl/wb_pipe_slave_ram.sv
// Wishbone B4 pipelined slave with a word-addressed RAM behind a small request queue.
// The queue head is the transaction in service; it is popped at the edge that launches its response.
module wb_pipe_slave_ram #(
   parameter int AW          = 16,
   parameter int DW          = 32,
   parameter int MEM_WORDS   = 256,
   parameter int QDEPTH      = 2,
   parameter int WAIT_STATES = 0
) (
   input  logic                CLK_I,
   input  logic                RST_I,
   wb_pipe_slave_ram_if.slave  wb
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH + 1);
   localparam int IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [AW:0] MEM_LIMIT = (AW + 1)'(MEM_WORDS);
   localparam logic [3:0]  WAIT_CNT  = 4'(WAIT_STATES);

   logic          q_we_q  [QDEPTH];
   logic [AW-1:0] q_adr_q [QDEPTH];
   logic [DW-1:0] q_dat_q [QDEPTH];
   logic [DW-1:0] mem_q   [MEM_WORDS];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          svc_q, svc_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          ack_q, ack_d;
   logic          err_q, err_d;
   logic          stall_q, stall_d;
   logic [DW-1:0] dat_q, dat_d;

   logic          push, respond, commit, entering, head_in_range;
   logic          head_we;
   logic [AW-1:0] head_adr;
   logic [DW-1:0] head_dat;
   logic [3:0]    cur_wait;
   logic          unused_lock;

   assign unused_lock = wb.LOCK_I;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // A head that is not yet in service enters now; it answers once WAIT_STATES edges have elapsed.
   always_comb begin
      push          = wb.CYC_I & wb.STB_I & ~stall_q;
      head_we       = q_we_q[rd_ptr_q];
      head_adr      = q_adr_q[rd_ptr_q];
      head_dat      = q_dat_q[rd_ptr_q];
      head_in_range = {1'b0, head_adr} < MEM_LIMIT;
      entering      = ~svc_q & (count_q != '0);
      cur_wait      = svc_q ? cnt_q : '0;
      respond       = wb.CYC_I & (svc_q | entering) & (cur_wait == WAIT_CNT);
      commit        = respond & head_we & head_in_range;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      svc_d    = svc_q;
      cnt_d    = cnt_q;
      stall_d  = stall_q;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      dat_d    = '0;

      if (!wb.CYC_I) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         svc_d    = 1'b0;
         cnt_d    = '0;
         stall_d  = 1'b0;
      end else begin
         if (push) begin
            wr_ptr_d = ptr_next(wr_ptr_q);
         end
         if (respond) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
            svc_d    = 1'b0;
            cnt_d    = '0;
            ack_d    = head_in_range;
            err_d    = ~head_in_range;
            if (head_in_range && !head_we) begin
               dat_d = mem_q[head_adr[IW-1:0]];
            end
         end else if (svc_q || entering) begin
            svc_d = 1'b1;
            cnt_d = cur_wait + 4'd1;
         end
         count_d = count_q + CW'(push) - CW'(respond);
         stall_d = (count_d == CW'(QDEPTH));
      end
   end

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         svc_q    <= 1'b0;
         cnt_q    <= '0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         stall_q  <= 1'b0;
         dat_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         svc_q    <= svc_d;
         cnt_q    <= cnt_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         stall_q  <= stall_d;
         dat_q    <= dat_d;
      end
   end

   // Storage carries no reset; entries are only consumed once pointers/count mark them valid.
   always_ff @(posedge CLK_I) begin
      if (push) begin
         q_we_q[wr_ptr_q]  <= wb.WE_I;
         q_adr_q[wr_ptr_q] <= wb.ADR_I;
         q_dat_q[wr_ptr_q] <= wb.DAT_I;
      end
      if (commit) begin
         mem_q[head_adr[IW-1:0]] <= head_dat;
      end
   end

   assign wb.ACK_O   = ack_q;
   assign wb.ERR_O   = err_q;
   assign wb.STALL_O = stall_q;
   assign wb.DAT_O   = dat_q;

endmodule

// File: tb/tb_wb_pipe_slave_ram.sv
// Scoreboard bench for wb_pipe_slave_ram: one instance with no wait states, one with two.
// Requests push expected responses; a negedge monitor pops and compares kind, data and arrival edge.
module tb_wb_pipe_slave_ram;

   typedef struct {
      bit          err;
      logic [31:0] data;
      bit          chk;
      int          due;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cycle;
   int   checks;
   int   failures;
   int   last_acc;
   int   last_due [2];
   int   ws [2];

   logic        cyc_i [2];
   logic        stb_i [2];
   logic        we_i  [2];
   logic [15:0] adr_i [2];
   logic [31:0] dat_i [2];
   logic        ack_o [2];
   logic        err_o [2];
   logic        stall_o [2];
   logic [31:0] dat_o [2];

   exp_t sb0[$];
   exp_t sb1[$];

   wb_pipe_slave_ram_if #(.AW(16), .DW(32)) bus0 ();
   wb_pipe_slave_ram_if #(.AW(16), .DW(32)) bus1 ();

   wb_pipe_slave_ram #(.AW(16), .DW(32), .MEM_WORDS(256), .QDEPTH(2), .WAIT_STATES(0)) u_dut0 (
      .CLK_I (clk),
      .RST_I (rst_n),
      .wb    (bus0)
   );

   wb_pipe_slave_ram #(.AW(16), .DW(32), .MEM_WORDS(256), .QDEPTH(2), .WAIT_STATES(2)) u_dut2 (
      .CLK_I (clk),
      .RST_I (rst_n),
      .wb    (bus1)
   );

   assign bus0.CYC_I  = cyc_i[0];
   assign bus0.STB_I  = stb_i[0];
   assign bus0.LOCK_I = 1'b0;
   assign bus0.WE_I   = we_i[0];
   assign bus0.ADR_I  = adr_i[0];
   assign bus0.DAT_I  = dat_i[0];
   assign bus1.CYC_I  = cyc_i[1];
   assign bus1.STB_I  = stb_i[1];
   assign bus1.LOCK_I = 1'b0;
   assign bus1.WE_I   = we_i[1];
   assign bus1.ADR_I  = adr_i[1];
   assign bus1.DAT_I  = dat_i[1];

   assign ack_o[0]   = bus0.ACK_O;
   assign err_o[0]   = bus0.ERR_O;
   assign stall_o[0] = bus0.STALL_O;
   assign dat_o[0]   = bus0.DAT_O;
   assign ack_o[1]   = bus1.ACK_O;
   assign err_o[1]   = bus1.ERR_O;
   assign stall_o[1] = bus1.STALL_O;
   assign dat_o[1]   = bus1.DAT_O;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   function automatic int sbSize(input int s);
      return (s == 0) ? sb0.size() : sb1.size();
   endfunction

   // Monitor body: protocol rules every cycle, and each response matched against the queue head.
   task automatic checkOutput(input int s);
      exp_t e;
      checkValue($sformatf("d%0d_ack_err_excl", s), {31'd0, ack_o[s] & err_o[s]}, 32'd0);
      if (!ack_o[s]) checkValue($sformatf("d%0d_dat_idle", s), dat_o[s], 32'd0);
      if (ack_o[s] || err_o[s]) begin
         if (sbSize(s) == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL d%0d_unexpected_resp: got ack=%0b err=%0b expected none (cycle %0d)",
                     s, ack_o[s], err_o[s], cycle);
         end else begin
            e = (s == 0) ? sb0.pop_front() : sb1.pop_front();
            checkValue($sformatf("d%0d_resp_kind", s), {30'd0, ack_o[s], err_o[s]},
                       e.err ? 32'd1 : 32'd2);
            if (e.chk) checkValue($sformatf("d%0d_read_data", s), dat_o[s], e.data);
            checkValue($sformatf("d%0d_resp_edge", s), cycle, e.due);
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput(0);
         checkOutput(1);
      end
   end

   // Holds the strobe until the slave is not stalling, then records the expected response.
   task automatic applyStimulus(input int s, input bit w, input logic [15:0] a, input logic [31:0] d,
                                input bit exp_resp, input bit exp_err, input logic [31:0] exp_data);
      bit   was_stall;
      bit   done;
      int   due;
      exp_t e;
      cyc_i[s] = 1'b1;
      stb_i[s] = 1'b1;
      we_i[s]  = w;
      adr_i[s] = a;
      dat_i[s] = d;
      done = 1'b0;
      for (int i = 0; i < 50 && !done; i++) begin
         was_stall = stall_o[s];
         @(posedge clk);
         #1;
         done = !was_stall;
      end
      if (!done) begin
         checks++;
         failures++;
         $display("[TB] FAIL d%0d_accept_timeout: got stalled expected accepted", s);
         return;
      end
      last_acc = cycle;
      if (exp_resp) begin
         due = cycle + 1 + ws[s];
         if (last_due[s] + ws[s] + 1 > due) due = last_due[s] + ws[s] + 1;
         last_due[s] = due;
         e = '{exp_err, exp_data, (!w && !exp_err), due};
         if (s == 0) sb0.push_back(e);
         else sb1.push_back(e);
      end
   endtask

   task automatic idle(input int s);
      stb_i[s] = 1'b0;
   endtask

   task automatic waitDrain(input int s);
      idle(s);
      for (int i = 0; i < 100 && sbSize(s) > 0; i++) @(negedge clk);
      @(posedge clk);
      #1;
      checkValue($sformatf("d%0d_drain", s), sbSize(s), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks   = 0;
      failures = 0;
      ws[0] = 0;
      ws[1] = 2;
      last_due[0] = -100;
      last_due[1] = -100;
      for (int s = 0; s < 2; s++) begin
         cyc_i[s] = 1'b0;
         stb_i[s] = 1'b0;
         we_i[s]  = 1'b0;
         adr_i[s] = '0;
         dat_i[s] = '0;
      end
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      for (int s = 0; s < 2; s++) begin
         checkValue("reset_ack",   {31'd0, ack_o[s]},   32'd0);
         checkValue("reset_err",   {31'd0, err_o[s]},   32'd0);
         checkValue("reset_stall", {31'd0, stall_o[s]}, 32'd0);
         checkValue("reset_dat",   dat_o[s],            32'd0);
      end
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      cyc_i[0] = 1'b1;
      cyc_i[1] = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] write then read back-to-back, zero wait states");
      applyStimulus(0, 1'b1, 16'd5, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
      checkValue("t1_stall_w", {31'd0, stall_o[0]}, 32'd0);
      applyStimulus(0, 1'b0, 16'd5, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
      checkValue("t1_stall_r", {31'd0, stall_o[0]}, 32'd0);
      waitDrain(0);

      $display("[TB] preload and four back-to-back reads");
      for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1, 16'(i), 32'h10 + 32'(i), 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1'b0, 16'(i), 32'h0, 1'b1, 1'b0, 32'h10 + 32'(i));
         checkValue("t2_no_stall", {31'd0, stall_o[0]}, 32'd0);
      end
      waitDrain(0);

      $display("[TB] out-of-range write then read of addr 0");
      applyStimulus(0, 1'b1, 16'd256, 32'h1, 1'b1, 1'b1, 32'h0);
      applyStimulus(0, 1'b0, 16'd0, 32'h0, 1'b1, 1'b0, 32'h10);
      applyStimulus(0, 1'b0, 16'd300, 32'h0, 1'b1, 1'b1, 32'h0);
      waitDrain(0);

      $display("[TB] two wait states: stall and response spacing");
      for (int i = 0; i < 4; i++) applyStimulus(1, 1'b1, 16'(i), 32'hA0 + 32'(i), 1'b1, 1'b0, 32'h0);
      waitDrain(1);
      applyStimulus(1, 1'b0, 16'd0, 32'h0, 1'b1, 1'b0, 32'hA0);
      checkValue("t3_stall_first", {31'd0, stall_o[1]}, 32'd0);
      applyStimulus(1, 1'b0, 16'd1, 32'h0, 1'b1, 1'b0, 32'hA1);
      checkValue("t3_stall_rise", {31'd0, stall_o[1]}, 32'd1);
      applyStimulus(1, 1'b0, 16'd2, 32'h0, 1'b1, 1'b0, 32'hA2);
      applyStimulus(1, 1'b0, 16'd3, 32'h0, 1'b1, 1'b0, 32'hA3);
      waitDrain(1);

      $display("[TB] abort with two writes outstanding");
      applyStimulus(1, 1'b1, 16'd10, 32'h11111111, 1'b1, 1'b0, 32'h0);
      applyStimulus(1, 1'b1, 16'd11, 32'h22222222, 1'b1, 1'b0, 32'h0);
      waitDrain(1);
      applyStimulus(1, 1'b1, 16'd10, 32'h55, 1'b0, 1'b0, 32'h0);
      applyStimulus(1, 1'b1, 16'd11, 32'h66, 1'b0, 1'b0, 32'h0);
      checkValue("t5_stall_pre", {31'd0, stall_o[1]}, 32'd1);
      cyc_i[1] = 1'b0;
      stb_i[1] = 1'b0;
      @(posedge clk);
      #1;
      checkValue("t5_stall_post", {31'd0, stall_o[1]}, 32'd0);
      repeat (6) @(posedge clk);
      #1;
      last_due[1] = -100;
      applyStimulus(1, 1'b0, 16'd10, 32'h0, 1'b1, 1'b0, 32'h11111111);
      applyStimulus(1, 1'b0, 16'd11, 32'h0, 1'b1, 1'b0, 32'h22222222);
      waitDrain(1);

      $display("[TB] asynchronous reset while a response is on the bus");
      applyStimulus(1, 1'b0, 16'd0, 32'h0, 1'b1, 1'b0, 32'hA0);
      applyStimulus(1, 1'b0, 16'd1, 32'h0, 1'b0, 1'b0, 32'h0);
      idle(1);
      repeat (2) @(posedge clk);
      #6;
      checkValue("t6_ack_before", {31'd0, ack_o[1]}, 32'd1);
      checkValue("t6_dat_before", dat_o[1], 32'hA0);
      rst_n = 1'b0;
      #1;
      checkValue("t6_rst_ack",   {31'd0, ack_o[1]},   32'd0);
      checkValue("t6_rst_err",   {31'd0, err_o[1]},   32'd0);
      checkValue("t6_rst_stall", {31'd0, stall_o[1]}, 32'd0);
      checkValue("t6_rst_dat",   dat_o[1],            32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      last_due[0] = -100;
      last_due[1] = -100;
      @(posedge clk);
      #1;
      applyStimulus(1, 1'b0, 16'd1, 32'h0, 1'b1, 1'b0, 32'hA1);
      waitDrain(1);

      waitDrain(0);
      waitDrain(1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
